// File: rtl/enc_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : enc_tick_gen
// Description : Encoder emulator. A phase accumulator turns a commanded RPM
//               into an encoder tick train, plus a once-per-revolution pulse.
//               Define ENC_QUAD_EN for a second quadrature channel (ticks_b)
//               with a direction input (cmd_dir).
// Revision    : 1.0 - initial release
// ============================================================================
module enc_tick_gen #(
  parameter int CLK_HZ  = 50000000,
  parameter int PPR     = 20,
  parameter int MAX_RPM = 2047,
  parameter int ACC_W   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [10:0] cmd_rpm,
`ifdef ENC_QUAD_EN
  input  logic        cmd_dir,
  output logic        ticks_b,
`endif
  output logic        cmd_ready,
  output logic        ticks,
  output logic        running,
  output logic        rev_pulse
);

`ifdef ENC_QUAD_EN
  localparam longint THRESH_L = (longint'(CLK_HZ) * 60) / (4 * PPR);
`else
  localparam longint THRESH_L = (longint'(CLK_HZ) * 60) / (2 * PPR);
`endif
  localparam logic [ACC_W-1:0] THRESH = ACC_W'(THRESH_L);

  localparam int          MAX_EFF   = (MAX_RPM > 2047) ? 2047 : MAX_RPM;
  localparam logic [10:0] MAX_RPM_C = 11'(MAX_EFF);

  localparam int                CNT_W    = (PPR > 1) ? $clog2(PPR) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PPR - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [10:0]      rpm_q, rpm_d;
  logic             ticks_q, ticks_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             running_q, running_d;
  logic             rev_q, rev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             w_accept;
  logic [10:0]      w_rpm_clamped;
  logic             w_active;
  logic [ACC_W-1:0] w_sum;
  logic             w_cross;
  logic             w_next_a;
  logic             w_wrap;
  logic             w_park;

  assign w_accept      = cmd_valid && cmd_ready_q;
  assign w_rpm_clamped = (cmd_rpm > MAX_RPM_C) ? MAX_RPM_C : cmd_rpm;
  assign w_active      = (state_q != ST_IDLE);
  assign w_sum         = acc_q + ACC_W'(rpm_q);
  assign w_cross       = w_active && (w_sum >= THRESH);

`ifdef ENC_QUAD_EN
  logic dir_q, dir_d;
  logic ticks_b_q, ticks_b_d;
  logic w_tog_a;
  logic w_next_b;

  // Gray step: forward moves A when the channels agree, reverse moves B.
  assign w_tog_a  = w_cross && ((ticks_q == ticks_b_q) == dir_q);
  assign w_next_a = ticks_q ^ w_tog_a;
  assign w_next_b = ticks_b_q ^ (w_cross && !w_tog_a);
  assign w_wrap   = w_cross && !w_next_a && !w_next_b;
  assign w_park   = w_wrap;
`else
  assign w_next_a = ticks_q ^ w_cross;
  assign w_wrap   = w_cross && !ticks_q;
  assign w_park   = w_cross && ticks_q;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rpm_d   = rpm_q;
    ticks_d = w_next_a;
    cnt_d   = cnt_q;
    rev_d   = 1'b0;
`ifdef ENC_QUAD_EN
    dir_d     = dir_q;
    ticks_b_d = w_next_b;
`endif

    if (w_cross) begin
      acc_d = w_sum - THRESH;
    end else if (w_active) begin
      acc_d = w_sum;
    end

    if (w_wrap) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        rev_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (w_accept && (w_rpm_clamped != 11'd0)) begin
          state_d = ST_RUN;
          rpm_d   = w_rpm_clamped;
`ifdef ENC_QUAD_EN
          dir_d   = cmd_dir;
`endif
        end
      end
      ST_RUN: begin
        // Rate changes keep the accumulator so the phase stays continuous.
        if (w_accept) begin
          if (w_rpm_clamped != 11'd0) begin
            rpm_d = w_rpm_clamped;
`ifdef ENC_QUAD_EN
            dir_d = cmd_dir;
`endif
          end else begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (w_park) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          rpm_d   = 11'd0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        acc_d   = '0;
        rpm_d   = 11'd0;
        cnt_d   = '0;
        ticks_d = 1'b0;
`ifdef ENC_QUAD_EN
        ticks_b_d = 1'b0;
`endif
      end
    endcase

    cmd_ready_d = (state_d != ST_STOP);
    running_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      rpm_q       <= 11'd0;
      ticks_q     <= 1'b0;
      cmd_ready_q <= 1'b1;
      running_q   <= 1'b0;
      rev_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rpm_q       <= rpm_d;
      ticks_q     <= ticks_d;
      cmd_ready_q <= cmd_ready_d;
      running_q   <= running_d;
      rev_q       <= rev_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef ENC_QUAD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q     <= 1'b1;
      ticks_b_q <= 1'b0;
    end else begin
      dir_q     <= dir_d;
      ticks_b_q <= ticks_b_d;
    end
  end

  assign ticks_b = ticks_b_q;
`endif

  assign cmd_ready = cmd_ready_q;
  assign ticks     = ticks_q;
  assign running   = running_q;
  assign rev_pulse = rev_q;

endmodule
`default_nettype wire

// File: doc/enc_tick_gen.md
Name: enc_tick_gen

Overview:
- Encoder emulator: produces an encoder-style `ticks` pulse train whose frequency matches a commanded RPM.
- Transmit-side counterpart of the tick-counting RPM measurement circuit. Used to drive that circuit in closed-loop test and to act as a motor stand-in on the board.
- Rate synthesis uses a phase accumulator, so no divider is needed.
- Commands arrive over a valid/ready handshake. Stops are glitch-free: `ticks` always parks low.

Parameters:
- CLK_HZ, 50000000: clock frequency in Hz.
- PPR, 20: encoder pulses (full tick periods) per revolution.
- MAX_RPM, 2047: command clamp ceiling; must satisfy MAX_RPM <= THRESH.
- ACC_W, 32: accumulator width; must hold THRESH+MAX_RPM.
- Derived localparam THRESH = CLK_HZ*60/(2*PPR). This is the half-period threshold. CLK_HZ*60 must divide exactly by 2*PPR.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command strobe.
- cmd_rpm  in  11  commanded speed, unsigned RPM.
- cmd_ready  out  1  block can accept a command.
- ticks  out  1  generated encoder pulse train.
- running  out  1  state is RUN or STOPPING.
- rev_pulse  out  1  one-cycle pulse per completed revolution.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: ticks=0, running=0, rev_pulse=0, cmd_ready=1, acc=0, rpm_q=0, edge counter=0, state=IDLE.
- Handshake:
  - A command is accepted when cmd_valid && cmd_ready at a rising edge of clk.
  - cmd_ready = (state != STOPPING), registered.
  - Accepted value rpm_q = min(cmd_rpm, MAX_RPM). It takes effect on the next cycle.
- Rate engine, active in RUN and STOPPING, each cycle:
  - sum = acc + rpm_q.
  - If sum >= THRESH: acc <= sum - THRESH and ticks toggles. Otherwise acc <= sum.
  - Resulting tick frequency = rpm_q*PPR/60 Hz; half period = THRESH/rpm_q clocks, averaged.
  - At most one toggle per cycle, guaranteed by MAX_RPM <= THRESH.
- States:
  - IDLE: ticks=0, acc=0.
    - Accept with rpm>0 -> RUN.
    - Accept with rpm=0 -> stay in IDLE.
  - RUN:
    - Accept with rpm>0: rpm_q updates; acc is NOT cleared, so phase stays continuous.
    - Accept with rpm=0: go to STOPPING. The old rpm_q is retained.
  - STOPPING:
    - Keeps generating at the old rate.
    - On the cycle ticks toggles 1->0: go to IDLE, acc=0, rpm_q=0.
    - If ticks is already 0 on entry, wait for the next rising then falling toggle, so a full final pulse is emitted. No runt pulses.
- Revolution count:
  - An internal counter of rising ticks edges wraps at PPR-1 -> 0.
  - rev_pulse is high for exactly one cycle, the cycle after the rising toggle that wraps the count.
  - The counter is cleared on entry to IDLE.
- Simultaneous events: an accept and a toggle in the same cycle both apply. The toggle uses the old rpm_q; the new rpm_q is used from the next cycle.
- Reset mid-operation: all outputs take reset values on the next edge, regardless of state. ticks drops to 0 immediately at that edge.

Optional Feature:
- Macro ENC_QUAD_EN.
- When defined:
  - Adds input cmd_dir (1 bit, latched with rpm_q on accept; 1 = forward) and output ticks_b (1 bit, reset 0).
  - THRESH becomes CLK_HZ*60/(4*PPR).
  - Each threshold crossing advances a 2-bit Gray phase {ticks,ticks_b}.
    - Forward: 00->10->11->01->00.
    - Reverse: 00->01->11->10->00.
  - STOPPING ends on reaching phase 00.
  - rev_pulse counts full cycles returning to 00.
- When undefined: single-channel behaviour above; no cmd_dir or ticks_b ports.

Test Plan:
- Reset: hold rst 3 cycles -> ticks=0, running=0, cmd_ready=1, rev_pulse=0.
- Default params, accept rpm=1500 -> running=1 next cycle. Toggles every 50000 clks, i.e. 500 Hz: period 100000 clks = 2 ms at 50 MHz. rev_pulse every 40 ms.
- Params CLK_HZ=1200, PPR=1 (THRESH=36000), rpm=600 -> toggles every 60 clks. Then accept rpm=1200 mid-half-period -> next toggle at 30 clks average, with no reset of phase.
- During RUN with ticks=1, accept rpm=0 -> cmd_ready=0. ticks falls at the normal half-period boundary, then IDLE, ticks stays 0, cmd_ready=1. Repeat with ticks=0 at accept -> one full pulse emitted before IDLE.
- cmd_rpm=2047 with MAX_RPM=1000 -> rate equals rpm 1000. Assert rst while ticks=1 -> ticks=0 on the next edge and state is IDLE.
- ENC_QUAD_EN, dir=1 then dir=0 at rpm=600, PPR=1, CLK_HZ=1200 (THRESH=18000) -> channel edges every 30 clks. Forward: ticks leads ticks_b by 90°. Reverse: ticks_b leads.
